// File: rtl/fibo_bcd_converter.sv
// Captures the calculator's 16-bit result on a rising result_ready and converts it to 5 packed BCD digits (double-dabble).
// Define SEVEN_SEG_EN to add the registered active-low seven-segment output seg_n.
module fibo_bcd_converter (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bin_in,
  input  logic        result_ready,
  output logic [19:0] bcd_out,
  output logic        valid,
  output logic        busy
`ifdef SEVEN_SEG_EN
  ,
  output logic [34:0] seg_n
`endif
);

  localparam int unsigned BIN_W   = 16;
  localparam int unsigned DIGITS  = 5;
  localparam int unsigned BCD_W   = 4 * DIGITS;
  localparam int unsigned SHIFT_W = BCD_W + BIN_W;
  localparam int unsigned CNT_W   = 5;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state, state_d;
  logic [SHIFT_W-1:0]   shift, shift_d, shift_adj;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [BCD_W-1:0]     bcd_d;
  logic                 valid_d;
  logic                 busy_d;
  logic                 ready_q;
  logic                 start;

  // Only a genuine 0->1 transition seen while idle starts a conversion
  assign start = result_ready && !ready_q && (state == IDLE);

  // Add-3 correction on every BCD nibble that is 5 or more
  always_comb begin
    shift_adj = shift;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (shift[BIN_W + 4*i +: 4] >= 4'd5)
        shift_adj[BIN_W + 4*i +: 4] = shift[BIN_W + 4*i +: 4] + 4'd3;
    end
  end

  // Next-state and datapath next values
  always_comb begin
    state_d = state;
    shift_d = shift;
    cnt_d   = cnt;
    bcd_d   = bcd_out;
    valid_d = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          shift_d = {BCD_W'(0), bin_in};
          cnt_d   = CNT_W'(0);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_d = {shift_adj[SHIFT_W-2:0], 1'b0};
        cnt_d   = cnt + CNT_W'(1);
        if (cnt == CNT_W'(BIN_W - 1))
          state_d = DONE;
      end
      DONE: begin
        bcd_d   = shift[SHIFT_W-1:BIN_W];
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      shift   <= '0;
      cnt     <= '0;
      bcd_out <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state   <= state_d;
      shift   <= shift_d;
      cnt     <= cnt_d;
      bcd_out <= bcd_d;
      valid   <= valid_d;
      busy    <= busy_d;
      ready_q <= result_ready;
    end
  end

`ifdef SEVEN_SEG_EN
  localparam int unsigned SEG_W = 7;

  logic [SEG_W*DIGITS-1:0] seg_d;
  logic                    leading;

  function automatic logic [SEG_W-1:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // Decode from the next bcd value so seg_n moves on the same edge as bcd_out
  always_comb begin
    seg_d   = '0;
    leading = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      if (leading && (bcd_d[4*i +: 4] == 4'd0)) begin
        seg_d[SEG_W*i +: SEG_W] = 7'h7F;
      end else begin
        leading                 = 1'b0;
        seg_d[SEG_W*i +: SEG_W] = seg7(bcd_d[4*i +: 4]);
      end
    end
    seg_d[SEG_W-1:0] = seg7(bcd_d[3:0]);
  end

  always_ff @(posedge clk) begin
    if (reset)
      seg_n <= {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
    else
      seg_n <= seg_d;
  end
`endif

endmodule

// File: tb/tb_fibo_bcd_converter.sv
// Directed self-checking bench for fibo_bcd_converter; seg_n checks are built only with SEVEN_SEG_EN.
module tb_fibo_bcd_converter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bin_in;
  logic        result_ready;
  logic [19:0] bcd_out;
  logic        valid;
  logic        busy;
`ifdef SEVEN_SEG_EN
  logic [34:0] seg_n;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fibo_bcd_converter dut (
    .clk          (clk),
    .reset        (reset),
    .bin_in       (bin_in),
    .result_ready (result_ready),
    .bcd_out      (bcd_out),
    .valid        (valid),
    .busy         (busy)
`ifdef SEVEN_SEG_EN
    ,
    .seg_n        (seg_n)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count cycles until valid, and busy samples seen on the way
  task automatic wait_valid(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    while (!valid && lat < 40) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
  endtask

  // Start a conversion from an idle, result_ready-low state and collect its result
  task automatic convert(input logic [15:0] value, output int lat, output int busy_cnt);
    bin_in       = value;
    result_ready = 1'b1;
    tick();
    wait_valid(lat, busy_cnt);
  endtask

  task automatic drop_ready();
    result_ready = 1'b0;
    tick();
  endtask

  initial begin
    int lat, bc, extra_valid, extra_busy;

    reset        = 1'b1;
    bin_in       = '0;
    result_ready = 1'b0;
    tick();
    tick();
    check("reset_bcd", 64'(bcd_out), 64'h0);
    check("reset_valid", 64'(valid), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);
`ifdef SEVEN_SEG_EN
    check("reset_seg", 64'(seg_n), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}));
`endif
    reset = 1'b0;
    tick();

    // Main conversion: latency and busy width
    convert(16'd46368, lat, bc);
    check("conv46368_latency", 64'(lat), 64'd17);
    check("conv46368_busy_cycles", 64'(bc), 64'd17);
    check("conv46368_bcd", 64'(bcd_out), 64'h46368);
    check("conv46368_busy_at_valid", 64'(busy), 64'h0);
    drop_ready();
    check("conv46368_valid_drop", 64'(valid), 64'h0);
    check("conv46368_bcd_hold", 64'(bcd_out), 64'h46368);

    convert(16'd0, lat, bc);
    check("conv0_bcd", 64'(bcd_out), 64'h00000);
    check("conv0_latency", 64'(lat), 64'd17);
    drop_ready();

    convert(16'd65535, lat, bc);
    check("conv65535_bcd", 64'(bcd_out), 64'h65535);
    drop_ready();

    // Second rising edge during SHIFT is ignored, held level does not retrigger
    bin_in       = 16'd1234;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    tick();
    tick();
    bin_in       = 16'd999;
    result_ready = 1'b1;
    tick();
    wait_valid(lat, bc);
    check("ignore_latency", 64'(lat + 3), 64'd17);
    check("ignore_bcd", 64'(bcd_out), 64'h01234);
    extra_valid = 0;
    extra_busy  = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (valid) extra_valid++;
      if (busy) extra_busy++;
    end
    check("held_no_valid", 64'(extra_valid), 64'd0);
    check("held_no_busy", 64'(extra_busy), 64'd0);
    check("held_bcd", 64'(bcd_out), 64'h01234);
    drop_ready();

    // result_ready high across reset release must not start
    result_ready = 1'b1;
    reset        = 1'b1;
    tick();
    tick();
    reset       = 1'b0;
    extra_busy  = 0;
    extra_valid = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (busy) extra_busy++;
      if (valid) extra_valid++;
    end
    check("rst_high_no_busy", 64'(extra_busy), 64'd0);
    check("rst_high_no_valid", 64'(extra_valid), 64'd0);
    drop_ready();
    convert(16'd9, lat, bc);
    check("conv9_bcd", 64'(bcd_out), 64'h00009);
    check("conv9_latency", 64'(lat), 64'd17);
    drop_ready();

    // Reset mid-conversion, at shift 8
    bin_in       = 16'd4321;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("midrst_busy_before", 64'(busy), 64'h1);
    reset = 1'b1;
    tick();
    check("midrst_busy", 64'(busy), 64'h0);
    check("midrst_bcd", 64'(bcd_out), 64'h0);
    reset       = 1'b0;
    extra_valid = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (valid) extra_valid++;
    end
    check("midrst_no_valid", 64'(extra_valid), 64'd0);
    check("midrst_bcd_after", 64'(bcd_out), 64'h0);

`ifdef SEVEN_SEG_EN
    convert(16'd610, lat, bc);
    check("seg610_bcd", 64'(bcd_out), 64'h00610);
    check("seg610_seg", 64'(seg_n), 64'({7'h7F, 7'h7F, 7'h02, 7'h79, 7'h40}));
    drop_ready();
    convert(16'd65535, lat, bc);
    check("seg65535_seg", 64'(seg_n), 64'({7'h02, 7'h12, 7'h12, 7'h30, 7'h12}));
    drop_ready();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
